// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage controller in front of data_memory. Accepts one load or
//   store, forms the effective address (base + offset, modular), classifies
//   the access, drives the memory for one ISSUE cycle and returns a single
//   cycle response to writeback.
//
//   State   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a request; classification happens on accept
//   ISSUE   | memory enable asserted for exactly this cycle
//   WAIT    | memory performs its registered read
//   CAPTURE | mem_rdata sampled into resp_data at the end of this cycle
//   DONE    | resp_valid pulse; returns to IDLE unconditionally
//
//   Optional build macro: LSU_MISALIGN_TRAP_EN
//     defined     -> misaligned half/word accesses fault, memory untouched
//     not defined -> no alignment check; ea is issued unchanged
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (req_ready doubles as stall)
//   req_load, req_store      access kind
//   req_funct3               RISC-V funct3, forwarded as load/store type
//   req_base, req_offset     effective address operands
//   req_wdata, req_rd        store data, destination register
//   mem_*                    data_memory drive (addr, data, types, enables)
//   mem_rdata                data_memory read data (registered by memory)
//   resp_valid               one-cycle response pulse
//   resp_data                load data / faulting ea / 0 for stores
//   resp_rd, resp_rd_we      writeback target and write enable
//   resp_fault               access rejected
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_load_type,
  output logic [2:0]  mem_store_type,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_rd_we,
  output logic        resp_fault
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

  state_t      state;
  logic        is_load;
  logic [31:0] ea;
  logic        illegal;
  logic        out_of_range;
  logic        misaligned;
  logic        fault;

  assign ea = req_base + req_offset;

  // Legal load types: 000,001,010,100,101. Legal store types: 000,001,010.
  always_comb begin
    illegal = 1'b0;
    if (req_load == req_store)
      illegal = 1'b1;
    else if (req_load)
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    else
      illegal = (req_funct3 > 3'b010);
  end

  assign out_of_range = (ea >= ADDR_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] encodes size for both loads and stores: 01 half, 10 word.
  assign misaligned = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault     = illegal | out_of_range | misaligned;
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_load        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_load_type  <= '0;
      mem_store_type <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_rd        <= '0;
      resp_rd_we     <= 1'b0;
      resp_fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rd <= req_rd;
            if (fault) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= ea;
              resp_rd_we <= 1'b0;
            end else begin
              // Address, data and types stay put until the next legal accept.
              state          <= ISSUE;
              is_load        <= req_load;
              mem_addr       <= ea;
              mem_wdata      <= req_wdata;
              mem_load_type  <= req_funct3;
              mem_store_type <= req_funct3;
              mem_read_en    <= req_load;
              mem_write_en   <= req_store;
            end
          end
        end
        ISSUE: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          if (is_load) begin
            state <= WAIT;
          end else begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= '0;
            resp_rd_we <= 1'b0;
          end
        end
        WAIT: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // Memory data is returned as-is; extension is the memory's job.
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_data  <= mem_rdata;
          resp_rd_we <= (resp_rd != 5'd0);
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rd_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
